// File: rtl/note_seq_pkg.sv
// Shared types and constants for the note sequencer: state encoding, default widths, tempo table.
// Latency: n/a (package only).
// Backpressure: n/a.
package note_seq_pkg;

   localparam int NOTE_W_DEF = 32;
   localparam int ADDR_W_DEF = 6;
   localparam int PERIOD_W   = 27;

   // Encoding is visible on the LEDs, so the values are fixed.
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_REC       = 2'd1,
      ST_PLAY      = 2'd2,
      ST_PLAY_WAIT = 2'd3
   } seq_state_e;

   // Beat period in 50 MHz cycles, indexed by the speed switches.
   localparam logic [PERIOD_W-1:0] PERIOD_TABLE [8] = '{
      27'd75000000, 27'd50000000, 27'd37500000, 27'd30000000,
      27'd25000000, 27'd21428571, 27'd16666667, 27'd13636364
   };

   // Scaled period, clamped to 2 so the down-counter always has a non-tick cycle.
   function automatic logic [PERIOD_W-1:0] beat_period(input logic [2:0] speed, input int shift);
      logic [PERIOD_W-1:0] p;
      p = PERIOD_TABLE[speed] >> shift;
      if (p < 27'd2) begin
         p = 27'd2;
      end
      return p;
   endfunction

endpackage

// File: rtl/note_sequencer_beat_timer.sv
// Tempo tick generator: down-counter reloaded with period-1 on load and on every tick.
// Latency: first tick exactly 'period' cycles after the load cycle.
// Backpressure: none; counter simply holds while enable is low.
module beat_timer
   import note_seq_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                load_i,
   input  logic                en_i,
   input  logic [PERIOD_W-1:0] period_i,
   output logic                tick_o
);

   logic [PERIOD_W-1:0] cnt_q;
   logic [PERIOD_W-1:0] cnt_d;

   // Next count: load wins, otherwise count down and reload on wrap (period re-sampled here).
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = period_i - 27'd1;
      end else if (en_i) begin
         if (cnt_q == '0) begin
            cnt_d = period_i - 27'd1;
         end else begin
            cnt_d = cnt_q - 27'd1;
         end
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/note_sequencer.sv
// Record/playback sequencer for the note RAM: owns address, write strobe and tempo tick.
// Latency: write on the tick cycle; playback strobe one cycle after the tick (RAM read latency).
// Backpressure: none; start commands are dropped unless idle, stop always honoured.
module note_sequencer
   import note_seq_pkg::*;
#(
   parameter int NOTE_W       = NOTE_W_DEF,
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int PERIOD_SHIFT = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_rec,
   input  logic              start_play,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [2:0]        speed,
   input  logic [NOTE_W-1:0] note_in,
   input  logic [NOTE_W-1:0] ram_q,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wren,
   output logic [NOTE_W-1:0] ram_wdata,
   output logic [NOTE_W-1:0] note_out,
   output logic              note_valid,
   output logic [ADDR_W:0]   rec_len,
   output logic              full,
   output logic              busy,
   output logic [1:0]        state
);

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   seq_state_e          state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W:0]     rec_len_q;
   logic                full_q;
   logic [NOTE_W-1:0]   note_q;

   logic                tick;
   logic                load;
   logic [PERIOD_W-1:0] period;
   logic [ADDR_W:0]     addr_inc;
   logic [ADDR_W:0]     rec_len_inc;

   assign period      = beat_period(speed, PERIOD_SHIFT);
   assign addr_inc    = {1'b0, addr_q} + 1'b1;
   assign rec_len_inc = rec_len_q + 1'b1;

   // The timer restarts on exactly the cycles the IDLE branch below accepts a command.
   assign load = (state_q == ST_IDLE) &&
                 (start_rec || (start_play && (rec_len_q != '0)));

   beat_timer u_beat_timer (
      .clk      (clk),
      .reset    (reset),
      .load_i   (load),
      .en_i     (state_q != ST_IDLE),
      .period_i (period),
      .tick_o   (tick)
   );

   // Sequencer FSM with its address, length, full flag and held note.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         rec_len_q <= '0;
         full_q    <= 1'b0;
         note_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_rec) begin
                  state_q   <= ST_REC;
                  addr_q    <= '0;
                  rec_len_q <= '0;
                  full_q    <= 1'b0;
               end else if (start_play && (rec_len_q != '0)) begin
                  state_q <= ST_PLAY;
                  addr_q  <= '0;
               end
            end
            ST_REC: begin
               // A tick's write is committed even when stop lands on the same cycle.
               if (tick) begin
                  addr_q    <= addr_inc[ADDR_W-1:0];
                  rec_len_q <= rec_len_inc;
                  if (rec_len_inc == DEPTH) begin
                     state_q <= ST_IDLE;
                     full_q  <= 1'b1;
                  end
               end
               if (stop) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_PLAY: begin
               if (stop) begin
                  state_q <= ST_IDLE;
               end else if (tick) begin
                  state_q <= ST_PLAY_WAIT;
               end
            end
            ST_PLAY_WAIT: begin
               note_q <= ram_q;
               if (addr_inc == rec_len_q) begin
                  if (loop_en && !stop) begin
                     addr_q  <= '0;
                     state_q <= ST_PLAY;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else begin
                  addr_q  <= addr_inc[ADDR_W-1:0];
                  state_q <= stop ? ST_IDLE : ST_PLAY;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // The strobe cycle shows ram_q directly so note_out and note_valid change together;
   // note_q holds that value afterwards.
   assign note_valid = (state_q == ST_PLAY_WAIT);
   assign note_out   = note_valid ? ram_q : note_q;

   assign ram_addr  = addr_q;
   assign ram_wren  = (state_q == ST_REC) && tick;
   assign ram_wdata = note_in;
   assign rec_len   = rec_len_q;
   assign full      = full_q;
   assign busy      = (state_q != ST_IDLE);
   assign state     = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a 1-cycle-latency RAM model.
// Latency: cycle 0 is the command-accepting cycle; outputs sampled 1 time unit after each edge.
// Backpressure: n/a.
module tb_note_sequencer;
   import note_seq_pkg::*;

   localparam int NW = 32;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          reset, start_rec, start_play, stop, loop_en;
   logic [2:0]    speed;
   logic [NW-1:0] note_in, ram_q;
   logic [AW-1:0] ram_addr;
   logic          ram_wren;
   logic [NW-1:0] ram_wdata, note_out;
   logic          note_valid;
   logic [AW:0]   rec_len;
   logic          full, busy;
   logic [1:0]    state;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   note_sequencer #(.NOTE_W(NW), .ADDR_W(AW), .PERIOD_SHIFT(20)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_rec  (start_rec),
      .start_play (start_play),
      .stop       (stop),
      .loop_en    (loop_en),
      .speed      (speed),
      .note_in    (note_in),
      .ram_q      (ram_q),
      .ram_addr   (ram_addr),
      .ram_wren   (ram_wren),
      .ram_wdata  (ram_wdata),
      .note_out   (note_out),
      .note_valid (note_valid),
      .rec_len    (rec_len),
      .full       (full),
      .busy       (busy),
      .state      (state)
   );

   // RAM model: synchronous read, plus a bench-side write port to overwrite contents.
   logic [NW-1:0] mem [64];
   logic          tb_we;
   logic [AW-1:0] tb_waddr;
   logic [NW-1:0] tb_wdata;

   always @(posedge clk) begin
      if (ram_wren) mem[ram_addr] <= ram_wdata;
      else if (tb_we) mem[tb_waddr] <= tb_wdata;
      ram_q <= mem[ram_addr];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [NW-1:0] rec_vals  [4];
   logic [NW-1:0] play_vals [3];
   int            ev_cyc [4];
   logic [AW-1:0] ev_adr [4];
   logic [NW-1:0] ev_dat [4];
   int            cnt;
   int            last_cyc;
   logic [AW-1:0] last_adr;

   initial begin
      rec_vals[0]  = 32'hA0A0_0001; rec_vals[1] = 32'hB0B0_0002;
      rec_vals[2]  = 32'hC0C0_0003; rec_vals[3] = 32'hDEAD_0004;
      play_vals[0] = 32'h1111_5A5A; play_vals[1] = 32'h2222_6B6B; play_vals[2] = 32'h3333_7C7C;

      reset = 1'b1; start_rec = 1'b0; start_play = 1'b0; stop = 1'b0; loop_en = 1'b0;
      speed = 3'd1; note_in = '0; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
      step();
      check("rst_state", state, ST_IDLE);
      check("rst_rec_len", rec_len, 0);
      check("rst_full", full, 0);
      check("rst_note_out", note_out, 0);
      check("rst_note_valid", note_valid, 0);
      check("rst_wren", ram_wren, 0);
      check("rst_addr", ram_addr, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      step();

      // start_play with nothing recorded is dropped; stop in IDLE does nothing.
      start_play = 1'b1; step(); start_play = 1'b0;
      check("play_empty_idle", state, ST_IDLE);
      step();
      check("play_empty_still_idle", state, ST_IDLE);
      stop = 1'b1; step(); stop = 1'b0;
      check("stop_idle_state", state, ST_IDLE);
      check("stop_idle_busy", busy, 0);

      // Simultaneous commands: record wins.
      start_rec = 1'b1; start_play = 1'b1; step(); start_rec = 1'b0; start_play = 1'b0;
      check("both_start_rec", state, ST_REC);
      check("both_busy", busy, 1);
      stop = 1'b1; step(); stop = 1'b0;
      check("both_stop_idle", state, ST_IDLE);
      check("both_rec_len", rec_len, 0);

      // Record three notes at P=47; note_in advances after each write.
      speed = 3'd1; note_in = rec_vals[0]; start_rec = 1'b1; cnt = 0;
      for (int c = 1; c <= 150; c++) begin
         step(); start_rec = 1'b0;
         if (ram_wren) begin
            if (cnt < 4) begin
               ev_cyc[cnt] = c; ev_adr[cnt] = ram_addr; ev_dat[cnt] = ram_wdata;
            end
            cnt++;
            note_in = rec_vals[(cnt < 4) ? cnt : 3];
         end
      end
      stop = 1'b1; step(); stop = 1'b0;
      check("rec3_writes", cnt, 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rec3_cyc%0d", i), ev_cyc[i], 47 * (i + 1));
         check($sformatf("rec3_adr%0d", i), ev_adr[i], i);
         check($sformatf("rec3_dat%0d", i), ev_dat[i], rec_vals[i]);
      end
      check("rec3_state", state, ST_IDLE);
      check("rec3_len", rec_len, 3);

      // Overwrite RAM so playback must come from the RAM read port.
      for (int i = 0; i < 3; i++) begin
         tb_we = 1'b1; tb_waddr = i[AW-1:0]; tb_wdata = play_vals[i];
         step();
      end
      tb_we = 1'b0;

      // Single-pass playback.
      loop_en = 1'b0; start_play = 1'b1; cnt = 0;
      for (int c = 1; c <= 200; c++) begin
         step(); start_play = 1'b0;
         if (note_valid) begin
            if (cnt < 4) begin ev_cyc[cnt] = c; ev_dat[cnt] = note_out; end
            cnt++;
         end
      end
      check("play_strobes", cnt, 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("play_cyc%0d", i), ev_cyc[i], 48 + 47 * i);
         check($sformatf("play_dat%0d", i), ev_dat[i], play_vals[i]);
      end
      check("play_end_state", state, ST_IDLE);
      check("play_hold_note", note_out, play_vals[2]);
      check("play_hold_len", rec_len, 3);

      // Looping playback: fourth strobe wraps to the first note, then stop in PLAY.
      loop_en = 1'b1; start_play = 1'b1; cnt = 0;
      for (int c = 1; c <= 400 && cnt < 4; c++) begin
         step(); start_play = 1'b0;
         if (note_valid) begin
            ev_cyc[cnt] = c; ev_dat[cnt] = note_out;
            cnt++;
         end
      end
      check("loop_strobes", cnt, 4);
      check("loop_cyc3", ev_cyc[3], 189);
      check("loop_dat3", ev_dat[3], play_vals[0]);
      step();
      check("loop_in_play", state, ST_PLAY);
      stop = 1'b1; step(); stop = 1'b0;
      check("loop_stop_idle", state, ST_IDLE);
      cnt = 0;
      for (int c = 0; c < 150; c++) begin
         step();
         if (note_valid) cnt++;
      end
      check("loop_no_more_strobes", cnt, 0);
      loop_en = 1'b0;

      // Fill all 64 entries at P=13 without stop.
      speed = 3'd7; note_in = 32'h0000_0100; start_rec = 1'b1; cnt = 0;
      last_cyc = 0; last_adr = '0;
      for (int c = 1; c <= 900; c++) begin
         step(); start_rec = 1'b0;
         if (ram_wren) begin
            cnt++; last_cyc = c; last_adr = ram_addr;
            note_in = note_in + 32'd1;
         end
      end
      check("full_writes", cnt, 64);
      check("full_last_addr", last_adr, 63);
      check("full_last_cyc", last_cyc, 832);
      check("full_state", state, ST_IDLE);
      check("full_flag", full, 1);
      check("full_len", rec_len, 64);

      // Reset in the middle of a recording after two writes.
      speed = 3'd1; start_rec = 1'b1; cnt = 0;
      step(); start_rec = 1'b0;
      check("rec_clears_full", full, 0);
      for (int c = 2; c <= 100; c++) begin
         step();
         if (ram_wren) cnt++;
      end
      check("midrec_writes", cnt, 2);
      check("midrec_addr", ram_addr, 2);
      reset = 1'b1; step(); reset = 1'b0;
      check("midrst_state", state, ST_IDLE);
      check("midrst_addr", ram_addr, 0);
      check("midrst_len", rec_len, 0);
      check("midrst_wren", ram_wren, 0);
      check("midrst_note", note_out, 0);
      check("midrst_full", full, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Sequences the 64x32 note RAM for record and playback, replacing the ad-hoc address counter and beat-clocked RAM port in the current datapath.
- Generates the tempo tick and owns the RAM address, write enable and write data.
- Tracks the recorded length, plays the RAM back in order with optional looping, and emits one note strobe per beat to the audio side.
- Sits between the top-level control FSM (start/stop commands) and the RAM / coordinates converter.

Parameters:
- NOTE_W, 32, width of one note word.
- ADDR_W, 6, RAM address width; depth = 2**ADDR_W = 64.
- PERIOD_SHIFT, 0, right shift applied to the beat-period table; simulation uses 20.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high.
- start_rec  in  1  one-cycle command: begin recording.
- start_play  in  1  one-cycle command: begin playback.
- stop  in  1  one-cycle command: end current operation.
- loop_en  in  1  playback wraps to address 0 after the last note.
- speed  in  3  tempo select (SW[2:0]).
- note_in  in  NOTE_W  converted note from coordinates converter.
- ram_q  in  NOTE_W  RAM read data, valid 1 cycle after the address is presented.
- ram_addr  out  ADDR_W  RAM address (the addr register).
- ram_wren  out  1  RAM write enable.
- ram_wdata  out  NOTE_W  RAM write data.
- note_out  out  NOTE_W  last played note, held between strobes.
- note_valid  out  1  one-cycle strobe when note_out updates.
- rec_len  out  ADDR_W+1  number of stored notes, 0..64.
- full  out  1  last recording stopped on depth limit.
- busy  out  1  state != IDLE.
- state  out  2  FSM state, for LEDs.

Behaviour:
- Reset (synchronous, any state including mid-operation):
  - state=IDLE, addr=0, rec_len=0, full=0.
  - note_out=0, note_valid=0, ram_wren=0.
  - Beat counter=0.
- Beat period P = max(TABLE[speed] >> PERIOD_SHIFT, 2). TABLE = 75000000, 50000000, 37500000, 30000000, 25000000, 21428571, 16666667, 13636364.
- Beat counter:
  - Loaded with P-1 on the cycle a start command is accepted; speed is sampled only at load and at wrap.
  - Counts down; tick=1 when counter==0, then reloads P-1.
  - First tick is P cycles after the accepting cycle.
  - The counter is frozen in IDLE.
- States (encoding): IDLE=0, REC=1, PLAY=2, PLAY_WAIT=3.
- IDLE:
  - start_rec -> REC; addr=0, rec_len=0, full=0.
  - Otherwise start_play with rec_len>0 -> PLAY; addr=0.
  - start_play with rec_len==0 is ignored.
  - Simultaneous start_rec and start_play: start_rec wins.
  - stop is ignored.
- REC:
  - On tick: ram_wren=1 for exactly that cycle, ram_wdata=note_in, write at addr; addr+1 (wraps to 0); rec_len+1.
  - If rec_len becomes 64 -> IDLE with full=1.
  - stop -> IDLE. If stop coincides with tick, the write completes first.
  - start_* commands are ignored outside IDLE.
- PLAY:
  - ram_addr=addr. On tick -> PLAY_WAIT.
  - stop -> IDLE with no strobe.
- PLAY_WAIT (one cycle):
  - note_out<=ram_q, note_valid=1.
  - If addr+1==rec_len: loop_en ? (addr=0, -> PLAY) : -> IDLE.
  - Else addr+1, -> PLAY.
  - stop here: the note is still emitted, then -> IDLE.
- rec_len and RAM contents persist across playbacks until the next start_rec or reset.
- ram_wdata is driven from note_in continuously; only ram_wren qualifies it.

Decomposition:
- Package note_seq_pkg holds:
  - the state enum;
  - NOTE_W and ADDR_W defaults;
  - the 8-entry period table;
  - function beat_period(speed, shift) implementing the clamp.
- Sub-module beat_timer: load, enable, period inputs; tick output; 27-bit down-counter.

Test Plan:
- Reset mid-REC after 2 writes → next cycle: state=0, addr=0, rec_len=0, ram_wren=0, note_out=0, full=0.
- PERIOD_SHIFT=20, speed=1 (P=47), start_rec, note_in=A,B,C changed between ticks → ram_wren pulses 47, 94, 141 cycles after start, addr 0/1/2, data A/B/C; stop → IDLE, rec_len=3.
- RAM model preloaded with X,Y,Z, rec_len=3, loop_en=0, start_play → note_valid at 48/95/142 cycles with note_out=X/Y/Z; IDLE after Z; note_out holds Z.
- loop_en=1, same setup → 4th strobe carries X; stop in PLAY → IDLE next cycle, no further strobes.
- Record 64 ticks, never asserting stop → 64th write at addr 63, then IDLE, full=1, rec_len=64, no 65th write.
- rec_len=0, start_play → stays IDLE. Assert start_rec and start_play together → REC. stop in IDLE → no effect.
